pe_spad_loader: RTL and testbench

//   Writer side of the PE scratchpad write ports. Accepts a valid/ready word stream from the

---
 rtl/pe_spad_loader.sv | 172 +++++++++++++++++
 tb/tb_pe_spad_loader.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/pe_spad_loader.sv
// Stream-to-scratchpad writer: filter SRAM load, then circular ifmap RF fill.
// Optional sticky protocol error flag built only with LOADER_ERR_CHECK_EN.
module pe_spad_loader #(
    parameter int WIDTH             = 4,
    parameter int SIZE_IFMAP        = 4,
    parameter int ADDR_WIDTH_IFMAP  = $clog2(SIZE_IFMAP),
    parameter int SIZE_SRAM         = 4,
    parameter int ADDR_WIDTH_FILTER = $clog2(SIZE_SRAM)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          stop,
    input  logic [ADDR_WIDTH_FILTER-1:0]  filt_len,
    input  logic                          in_valid,
    input  logic [WIDTH-1:0]              in_data,
    output logic                          in_ready,
    input  logic                          ifmap_pop,
    output logic                          filter_wen,
    output logic [ADDR_WIDTH_FILTER-1:0]  filter_w_addr,
    output logic [WIDTH-1:0]              filter_din,
    output logic                          ifmap_wen,
    output logic [ADDR_WIDTH_IFMAP-1:0]   ifmap_w_addr,
    output logic [WIDTH-1:0]              ifmap_din,
    output logic [$clog2(SIZE_IFMAP+1)-1:0] ifmap_count,
    output logic                          ifmap_full,
    output logic                          filter_done,
    output logic                          busy,
    output logic                          err
);
    localparam int FW = ADDR_WIDTH_FILTER;
    localparam int IW = ADDR_WIDTH_IFMAP;
    localparam int CW = $clog2(SIZE_IFMAP+1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_FILTER = 2'd1;
    localparam logic [1:0] S_IFMAP  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [FW-1:0]    fptr_q, fptr_d;
    logic [FW-1:0]    last_q, last_d;
    logic [IW-1:0]    wptr_q, wptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             f_wen_q, f_wen_d;
    logic [FW-1:0]    f_addr_q, f_addr_d;
    logic [WIDTH-1:0] f_din_q, f_din_d;
    logic             done_q, done_d;
    logic             i_wen_q, i_wen_d;
    logic [IW-1:0]    i_addr_q, i_addr_d;
    logic [WIDTH-1:0] i_din_q, i_din_d;
    logic             rdy, xfer, full, pop_ok, inc;

    assign full   = (count_q == CW'(SIZE_IFMAP));
    assign pop_ok = ifmap_pop && (count_q != '0);
    assign xfer   = in_valid && rdy;

    // A pop frees a slot in the same cycle, so a full buffer may still accept.
    always_comb begin
        rdy = 1'b0;
        case (state_q)
            S_FILTER: rdy = 1'b1;
            S_IFMAP:  rdy = !full || ifmap_pop;
            default:  rdy = 1'b0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        fptr_d   = fptr_q;
        last_d   = last_q;
        wptr_d   = wptr_q;
        f_wen_d  = 1'b0;
        f_addr_d = f_addr_q;
        f_din_d  = f_din_q;
        done_d   = 1'b0;
        i_wen_d  = 1'b0;
        i_addr_d = i_addr_q;
        i_din_d  = i_din_q;
        inc      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    last_d  = (filt_len == '0) ? FW'(SIZE_SRAM-1)
                                               : filt_len - FW'(1);
                    fptr_d  = '0;
                    state_d = S_FILTER;
                end
            end
            S_FILTER: begin
                if (xfer) begin
                    f_wen_d  = 1'b1;
                    f_addr_d = fptr_q;
                    f_din_d  = in_data;
                    fptr_d   = fptr_q + FW'(1);
                    if (fptr_q == last_q) begin
                        done_d  = 1'b1;
                        state_d = S_IFMAP;
                    end
                end
            end
            S_IFMAP: begin
                if (xfer) begin
                    i_wen_d  = 1'b1;
                    i_addr_d = wptr_q;
                    i_din_d  = in_data;
                    inc      = 1'b1;
                    wptr_d   = (wptr_q == IW'(SIZE_IFMAP-1)) ? '0
                                                             : wptr_q + IW'(1);
                end
                if (stop) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        count_d = count_q;
        if (inc && !pop_ok)      count_d = count_q + CW'(1);
        else if (!inc && pop_ok) count_d = count_q - CW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            fptr_q   <= '0;
            last_q   <= '0;
            wptr_q   <= '0;
            count_q  <= '0;
            f_wen_q  <= 1'b0;
            f_addr_q <= '0;
            f_din_q  <= '0;
            done_q   <= 1'b0;
            i_wen_q  <= 1'b0;
            i_addr_q <= '0;
            i_din_q  <= '0;
        end else begin
            state_q  <= state_d;
            fptr_q   <= fptr_d;
            last_q   <= last_d;
            wptr_q   <= wptr_d;
            count_q  <= count_d;
            f_wen_q  <= f_wen_d;
            f_addr_q <= f_addr_d;
            f_din_q  <= f_din_d;
            done_q   <= done_d;
            i_wen_q  <= i_wen_d;
            i_addr_q <= i_addr_d;
            i_din_q  <= i_din_d;
        end
    end

`ifdef LOADER_ERR_CHECK_EN
    logic err_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_q <= 1'b0;
        else if ((ifmap_pop && count_q == '0) || (start && state_q != S_IDLE))
            err_q <= 1'b1;
    end
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign in_ready      = rdy;
    assign filter_wen    = f_wen_q;
    assign filter_w_addr = f_addr_q;
    assign filter_din    = f_din_q;
    assign filter_done   = done_q;
    assign ifmap_wen     = i_wen_q;
    assign ifmap_w_addr  = i_addr_q;
    assign ifmap_din     = i_din_q;
    assign ifmap_count   = count_q;
    assign ifmap_full    = full;
    assign busy          = (state_q != S_IDLE);
endmodule

// File: tb/tb_pe_spad_loader.sv
// Directed bench for pe_spad_loader: filter load, ifmap wrap, pop/stop, reset.
module tb_pe_spad_loader;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0, stop = 1'b0, in_valid = 1'b0, ifmap_pop = 1'b0;
    logic [1:0] filt_len = '0;
    logic [3:0] in_data = '0;
    logic       in_ready, filter_wen, ifmap_wen, ifmap_full;
    logic       filter_done, busy, err;
    logic [1:0] filter_w_addr, ifmap_w_addr;
    logic [3:0] filter_din, ifmap_din;
    logic [2:0] ifmap_count;

    int n_chk = 0;
    int n_fail = 0;

`ifdef LOADER_ERR_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    pe_spad_loader dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .filt_len(filt_len), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .ifmap_pop(ifmap_pop),
        .filter_wen(filter_wen), .filter_w_addr(filter_w_addr),
        .filter_din(filter_din), .ifmap_wen(ifmap_wen),
        .ifmap_w_addr(ifmap_w_addr), .ifmap_din(ifmap_din),
        .ifmap_count(ifmap_count), .ifmap_full(ifmap_full),
        .filter_done(filter_done), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, "_ready"}, in_ready, 0);
        chk({tag, "_fwen"}, filter_wen, 0);
        chk({tag, "_faddr"}, filter_w_addr, 0);
        chk({tag, "_fdin"}, filter_din, 0);
        chk({tag, "_iwen"}, ifmap_wen, 0);
        chk({tag, "_iaddr"}, ifmap_w_addr, 0);
        chk({tag, "_idin"}, ifmap_din, 0);
        chk({tag, "_count"}, ifmap_count, 0);
        chk({tag, "_full"}, ifmap_full, 0);
        chk({tag, "_done"}, filter_done, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_err"}, err, 0);
    endtask

    initial begin
        #3;
        chk_idle_zero("rst");
        @(negedge clk);
        rst = 1'b0;

        // 1: three filter words
        filt_len = 2'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t1_busy", busy, 1);
        chk("t1_ready", in_ready, 1);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data = 4'(i + 1);
            tick();
            chk("t1_fwen", filter_wen, 1);
            chk("t1_faddr", filter_w_addr, i);
            chk("t1_fdin", filter_din, i + 1);
            chk("t1_done", filter_done, (i == 2) ? 1 : 0);
            chk("t1_iwen", ifmap_wen, 0);
        end
        in_valid = 1'b0;
        #1;
        chk("t1_ifm_ready", in_ready, 1);
        chk("t1_ifm_busy", busy, 1);
        tick();
        chk("t1_fwen_off", filter_wen, 0);
        chk("t1_done_off", filter_done, 0);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("t1_idle_busy", busy, 0);
        chk("t1_idle_ready", in_ready, 0);

        // 2: filt_len 0 loads the full SRAM
        filt_len = 2'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data = 4'(i + 5);
            tick();
            chk("t2_fwen", filter_wen, 1);
            chk("t2_faddr", filter_w_addr, i);
            chk("t2_fdin", filter_din, i + 5);
            chk("t2_done", filter_done, (i == 3) ? 1 : 0);
        end

        // 3: fill ifmap, then wrap on pop
        for (int i = 0; i < 4; i++) begin
            in_data = 4'(10 + i);
            tick();
            chk("t3_fwen", filter_wen, 0);
            chk("t3_iwen", ifmap_wen, 1);
            chk("t3_iaddr", ifmap_w_addr, i);
            chk("t3_idin", ifmap_din, 10 + i);
            chk("t3_count", ifmap_count, i + 1);
        end
        chk("t3_full", ifmap_full, 1);
        in_data = 4'hE;
        #1;
        chk("t3_ready_full", in_ready, 0);
        tick();
        chk("t3_stall_wen", ifmap_wen, 0);
        chk("t3_stall_cnt", ifmap_count, 4);
        ifmap_pop = 1'b1;
        #1;
        chk("t3_pop_ready", in_ready, 1);
        tick();
        chk("t3_wrap_wen", ifmap_wen, 1);
        chk("t3_wrap_addr", ifmap_w_addr, 0);
        chk("t3_wrap_din", ifmap_din, 4'hE);
        chk("t3_wrap_cnt", ifmap_count, 4);

        // 4: pop and push together while full
        for (int i = 0; i < 3; i++) begin
            in_data = 4'(i + 1);
            #1;
            chk("t4_ready", in_ready, 1);
            tick();
            chk("t4_iwen", ifmap_wen, 1);
            chk("t4_iaddr", ifmap_w_addr, i + 1);
            chk("t4_idin", ifmap_din, i + 1);
            chk("t4_count", ifmap_count, 4);
        end

        // 5: transfer coincident with stop
        in_valid = 1'b0;
        tick();
        chk("t5_popcnt", ifmap_count, 3);
        ifmap_pop = 1'b0;
        in_valid = 1'b1;
        in_data = 4'h5;
        stop = 1'b1;
        #1;
        chk("t5_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        stop = 1'b0;
        chk("t5_iwen", ifmap_wen, 1);
        chk("t5_iaddr", ifmap_w_addr, 0);
        chk("t5_idin", ifmap_din, 5);
        chk("t5_count", ifmap_count, 4);
        chk("t5_busy", busy, 0);
        chk("t5_ready_idle", in_ready, 0);
        tick();
        chk("t5_iwen_off", ifmap_wen, 0);

        // 6: drain in IDLE, underflow pop, then reset mid filter load
        ifmap_pop = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t6_drain", ifmap_count, (i < 4) ? 3 - i : 0);
        end
        ifmap_pop = 1'b0;
        tick();
        chk("t6_err", err, EXP_ERR);
        tick();
        chk("t6_err_hold", err, EXP_ERR);
        filt_len = 2'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        in_valid = 1'b1;
        in_data = 4'h9;
        tick();
        chk("t6_pre_fwen", filter_wen, 1);
        rst = 1'b1;
        #1;
        chk_idle_zero("t6_rst");
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk("t6_post_busy", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
